// File: rtl/fifo_grey_pkg.sv
// Shared helpers for the async-FIFO pointer logic: Gray/binary conversion,
// pointer-width helpers and elaboration-time parameter checks.
package fifo_grey_pkg;

  localparam int MAX_W         = 32;
  localparam int DEFAULT_DEPTH = 8;
  localparam int ADDR_W        = $clog2(DEFAULT_DEPTH);
  localparam int PTR_W         = ADDR_W + 1;

  function automatic int addr_w_of(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int ptr_w_of(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic [MAX_W-1:0] bin2grey(input logic [MAX_W-1:0] b, input int width);
    logic [MAX_W-1:0] m;
    m = (width >= MAX_W) ? {MAX_W{1'b1}} : ((MAX_W'(1) << width) - MAX_W'(1));
    return (b & m) ^ ((b & m) >> 1);
  endfunction

  // Bits at or above width are forced to zero so the top bit of the pointer
  // starts the prefix-XOR chain.
  function automatic logic [MAX_W-1:0] grey2bin(input logic [MAX_W-1:0] g, input int width);
    logic [MAX_W-1:0] b;
    b = '0;
    b[MAX_W-1] = (width >= MAX_W) ? g[MAX_W-1] : 1'b0;
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = (i < width) ? (b[i+1] ^ g[i]) : 1'b0;
    end
    return b;
  endfunction

  function automatic bit thresholds_ok(input int depth, input int af_th, input int ae_th);
    return (ae_th > 0) && (ae_th < af_th) && (af_th <= depth);
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 4) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_grey_ptr_sync_status_sync.sv
// Plain reset-to-zero flop chain used to bring a Gray pointer across clock domains.
module grey_sync_chain #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_r [STAGES];

  // Shift the remote pointer through the synchroniser stages.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_r[i] <= '0;
      end
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign q = stage_r[STAGES-1];

endmodule

// File: rtl/fifo_grey_ptr_sync_status.sv
// Async-FIFO status block: synchronises the remote Gray pointer and produces
// registered level, full/empty, almost flags and a sticky pointer-error flag.
module fifo_grey_ptr_sync_status
  import fifo_grey_pkg::*;
#(
  parameter int FIFO_DEPTH      = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int LOCAL_IS_WRITE  = 1,
  parameter int ALMOST_FULL_TH  = FIFO_DEPTH - 2,
  parameter int ALMOST_EMPTY_TH = 2,
  localparam int PW             = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [PW-1:0] local_ptr_next,
  input  logic [PW-1:0] remote_ptr,
  output logic [PW-1:0] remote_ptr_sync,
  output logic [PW-1:0] level,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          ptr_error
);

  localparam logic [PW-1:0] DEPTH_V = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] AF_V    = PW'(ALMOST_FULL_TH);
  localparam logic [PW-1:0] AE_V    = PW'(ALMOST_EMPTY_TH);

  if (!depth_ok(FIFO_DEPTH)) begin : g_bad_depth
    $fatal(1, "FIFO_DEPTH must be a power of two and at least 4");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $fatal(1, "SYNC_STAGES must be at least 2");
  end
  if (!thresholds_ok(FIFO_DEPTH, ALMOST_FULL_TH, ALMOST_EMPTY_TH)) begin : g_bad_th
    $fatal(1, "need 0 < ALMOST_EMPTY_TH < ALMOST_FULL_TH <= FIFO_DEPTH");
  end

  logic [PW-1:0] local_bin_s;
  logic [PW-1:0] remote_bin_s;
  logic [PW-1:0] wr_bin_s;
  logic [PW-1:0] rd_bin_s;
  logic [PW-1:0] dist_s;

  logic [PW-1:0] level_r;
  logic          full_r;
  logic          empty_r;
  logic          almost_full_r;
  logic          almost_empty_r;
  logic          ptr_error_r;

  grey_sync_chain #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (remote_ptr),
    .q     (remote_ptr_sync)
  );

  // Occupancy distance; modulo arithmetic absorbs pointer wrap-around.
  always_comb begin
    local_bin_s  = PW'(grey2bin(MAX_W'(local_ptr_next), PW));
    remote_bin_s = PW'(grey2bin(MAX_W'(remote_ptr_sync), PW));
    if (LOCAL_IS_WRITE != 0) begin
      wr_bin_s = local_bin_s;
      rd_bin_s = remote_bin_s;
    end else begin
      wr_bin_s = remote_bin_s;
      rd_bin_s = local_bin_s;
    end
    dist_s = wr_bin_s - rd_bin_s;
  end

  // Status registers; an impossible distance freezes status and latches the error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      level_r        <= '0;
      full_r         <= 1'b0;
      empty_r        <= 1'b1;
      almost_full_r  <= 1'b0;
      almost_empty_r <= 1'b1;
      ptr_error_r    <= 1'b0;
    end else if (dist_s <= DEPTH_V) begin
      level_r        <= dist_s;
      full_r         <= (dist_s == DEPTH_V);
      empty_r        <= (dist_s == '0);
      almost_full_r  <= (dist_s >= AF_V);
      almost_empty_r <= (dist_s <= AE_V);
      ptr_error_r    <= ptr_error_r;
    end else begin
      ptr_error_r    <= 1'b1;
    end
  end

  assign level        = level_r;
  assign full         = full_r;
  assign empty        = empty_r;
  assign almost_full  = almost_full_r;
  assign almost_empty = almost_empty_r;
  assign ptr_error    = ptr_error_r;

endmodule

// File: tb/tb_fifo_grey_ptr_sync_status.sv
// Directed bench: write-side and read-side instances, table-driven fill/drain
// plus hand sequences for synchroniser latency, wrap, error and reset.
module tb_fifo_grey_ptr_sync_status;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] wr_local, wr_remote, wr_sync, wr_level;
  logic       wr_full, wr_empty, wr_af, wr_ae, wr_err;
  logic [3:0] rd_local, rd_remote, rd_sync, rd_level;
  logic       rd_full, rd_empty, rd_af, rd_ae, rd_err;

  fifo_grey_ptr_sync_status #(.FIFO_DEPTH(8), .SYNC_STAGES(2), .LOCAL_IS_WRITE(1)) dut_wr (
    .clk(clk), .reset(reset), .local_ptr_next(wr_local), .remote_ptr(wr_remote),
    .remote_ptr_sync(wr_sync), .level(wr_level), .full(wr_full), .empty(wr_empty),
    .almost_full(wr_af), .almost_empty(wr_ae), .ptr_error(wr_err));

  fifo_grey_ptr_sync_status #(.FIFO_DEPTH(8), .SYNC_STAGES(2), .LOCAL_IS_WRITE(0)) dut_rd (
    .clk(clk), .reset(reset), .local_ptr_next(rd_local), .remote_ptr(rd_remote),
    .remote_ptr_sync(rd_sync), .level(rd_level), .full(rd_full), .empty(rd_empty),
    .almost_full(rd_af), .almost_empty(rd_ae), .ptr_error(rd_err));

  typedef struct {
    logic [3:0] lp;
    logic [3:0] rp;
    logic [3:0] lvl;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       err;
  } vec_t;

  vec_t fill_tab[9];
  vec_t drain_tab[6];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic [3:0] lvl, input logic f, input logic e,
                          input logic af, input logic ae, input logic err);
    check({tag, ".wr_level"}, 8'(wr_level), 8'(lvl));
    check({tag, ".wr_full"}, 8'(wr_full), 8'(f));
    check({tag, ".wr_empty"}, 8'(wr_empty), 8'(e));
    check({tag, ".wr_almost_full"}, 8'(wr_af), 8'(af));
    check({tag, ".wr_almost_empty"}, 8'(wr_ae), 8'(ae));
    check({tag, ".wr_ptr_error"}, 8'(wr_err), 8'(err));
  endtask

  task automatic check_rd(input string tag, input logic [3:0] lvl, input logic f, input logic e,
                          input logic af, input logic ae, input logic err);
    check({tag, ".rd_level"}, 8'(rd_level), 8'(lvl));
    check({tag, ".rd_full"}, 8'(rd_full), 8'(f));
    check({tag, ".rd_empty"}, 8'(rd_empty), 8'(e));
    check({tag, ".rd_almost_full"}, 8'(rd_af), 8'(af));
    check({tag, ".rd_almost_empty"}, 8'(rd_ae), 8'(ae));
    check({tag, ".rd_ptr_error"}, 8'(rd_err), 8'(err));
  endtask

  initial begin
    // Write side fill, remote read pointer at 0: local = Gray(0..8).
    fill_tab[0] = '{4'b0000, 4'b0000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    fill_tab[1] = '{4'b0001, 4'b0000, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    fill_tab[2] = '{4'b0011, 4'b0000, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    fill_tab[3] = '{4'b0010, 4'b0000, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    fill_tab[4] = '{4'b0110, 4'b0000, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    fill_tab[5] = '{4'b0111, 4'b0000, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    fill_tab[6] = '{4'b0101, 4'b0000, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    fill_tab[7] = '{4'b0100, 4'b0000, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    fill_tab[8] = '{4'b1100, 4'b0000, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    // Read side drain, remote write pointer Gray(5) = 0111: local = Gray(0..5).
    drain_tab[0] = '{4'b0000, 4'b0111, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    drain_tab[1] = '{4'b0001, 4'b0111, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    drain_tab[2] = '{4'b0011, 4'b0111, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    drain_tab[3] = '{4'b0010, 4'b0111, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    drain_tab[4] = '{4'b0110, 4'b0111, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    drain_tab[5] = '{4'b0111, 4'b0111, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset held for 3 edges with random inputs.
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_local  = 4'($urandom);
      wr_remote = 4'($urandom);
      rd_local  = 4'($urandom);
      rd_remote = 4'($urandom);
      tick();
    end
    check_wr("reset", 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("reset.wr_sync", 8'(wr_sync), 8'h00);
    check_rd("reset", 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("reset.rd_sync", 8'(rd_sync), 8'h00);
    wr_local = 4'b0000; wr_remote = 4'b0000; rd_local = 4'b0000; rd_remote = 4'b0000;
    reset = 1'b1;

    // Fill: local-side changes land on the same edge.
    for (int i = 0; i < 9; i++) begin
      wr_local  = fill_tab[i].lp;
      wr_remote = fill_tab[i].rp;
      tick();
      check_wr($sformatf("fill%0d", i), fill_tab[i].lvl, fill_tab[i].full, fill_tab[i].empty,
               fill_tab[i].af, fill_tab[i].ae, fill_tab[i].err);
    end

    // Remote latency: read pointer moves 0 -> Gray(3) before edge t.
    wr_remote = 4'b0010;
    tick();
    check("lat.t.sync", 8'(wr_sync), 8'h00);
    check("lat.t.level", 8'(wr_level), 8'd8);
    tick();
    check("lat.t1.full", 8'(wr_full), 8'd1);
    tick();
    check("lat.t2.sync", 8'(wr_sync), 8'b0010);
    tick();
    check_wr("lat.t3", 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Wrap: bring remote to 8, local to 15, remote to 12, then local 15 -> 0.
    wr_remote = 4'b1100;
    for (int i = 0; i < 3; i++) tick();
    check("wrap.caught_up.level", 8'(wr_level), 8'd0);
    wr_local = 4'b1000;
    tick();
    check("wrap.local15.level", 8'(wr_level), 8'd7);
    wr_remote = 4'b1010;
    for (int i = 0; i < 3; i++) tick();
    check_wr("wrap.pre", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wr_local = 4'b0000;
    tick();
    check_wr("wrap.post", 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("wrap.sync", 8'(wr_sync), 8'b1010);

    // Mid-operation reset clears everything.
    reset = 1'b0;
    tick();
    check_wr("midreset", 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("midreset.sync", 8'(wr_sync), 8'h00);
    wr_local = 4'b0000; wr_remote = 4'b0000;
    tick();
    reset = 1'b1;
    tick();

    // Error: local Gray 1101 = binary 9, distance exceeds depth.
    wr_local = 4'b1101;
    tick();
    check_wr("err.set", 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    wr_local = 4'b0000;
    tick();
    check("err.sticky1", 8'(wr_err), 8'd1);
    check("err.sticky1.level", 8'(wr_level), 8'd0);
    tick();
    check("err.sticky2", 8'(wr_err), 8'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("err.cleared", 8'(wr_err), 8'd0);
    check_rd("rd.idle", 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Read side: write pointer Gray(5) synchronised, then drain.
    rd_remote = 4'b0111;
    rd_local  = 4'b0000;
    for (int i = 0; i < 3; i++) tick();
    check("rd.sync", 8'(rd_sync), 8'b0111);
    for (int i = 0; i < 6; i++) begin
      rd_local  = drain_tab[i].lp;
      rd_remote = drain_tab[i].rp;
      tick();
      check_rd($sformatf("drain%0d", i), drain_tab[i].lvl, drain_tab[i].full, drain_tab[i].empty,
               drain_tab[i].af, drain_tab[i].ae, drain_tab[i].err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
